// File: rtl/wb_timer_pkg.sv
// Shared register map, CTRL field positions and bus types for wb_multi_timer.
package wb_timer_pkg;

  localparam int unsigned DATA_W       = 32;
  localparam int unsigned MAX_CH       = 8;
  localparam int unsigned PRESCALE_W   = 16;
  localparam int unsigned CTRL_EN_LSB  = 0;
  localparam int unsigned CTRL_PER_LSB = 8;

  localparam logic [4:0] OFF_CTRL     = 5'd0;
  localparam logic [4:0] OFF_STATUS   = 5'd1;
  localparam logic [4:0] OFF_MASK     = 5'd2;
  localparam logic [4:0] OFF_PRESCALE = 5'd3;
  localparam logic [4:0] OFF_LOAD0    = 5'd4;

  typedef enum logic [1:0] {
    BUS_IDLE = 2'b00,
    BUS_ACK  = 2'b01,
    BUS_RTY  = 2'b10
  } bus_state_e;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_MASK,
    REG_PRESCALE,
    REG_LOAD,
    REG_COUNT,
    REG_NONE
  } reg_kind_e;

  typedef struct packed {
    reg_kind_e  kind;
    logic [2:0] ch;
  } reg_dec_t;

  // Offsets 4.. alternate LOAD/COUNT per channel; channels past num_ch are unmapped.
  function automatic reg_dec_t decode_offset(input logic [4:0] off,
                                             input int unsigned num_ch,
                                             input bit prescale_en);
    reg_dec_t   d;
    logic [4:0] idx;
    d.kind = REG_NONE;
    d.ch   = '0;
    idx    = off - OFF_LOAD0;
    if (off == OFF_CTRL) begin
      d.kind = REG_CTRL;
    end else if (off == OFF_STATUS) begin
      d.kind = REG_STATUS;
    end else if (off == OFF_MASK) begin
      d.kind = REG_MASK;
    end else if (off == OFF_PRESCALE) begin
      if (prescale_en) d.kind = REG_PRESCALE;
    end else if (32'(idx[4:1]) < num_ch) begin
      d.kind = idx[0] ? REG_COUNT : REG_LOAD;
      d.ch   = idx[3:1];
    end
    return d;
  endfunction

endpackage

// File: rtl/wb_timer_channel.sv
// One timer channel: LOAD register, up-counter, terminal compare and mode handling.
import wb_timer_pkg::*;

module wb_timer_channel #(
  parameter int unsigned CNT_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             enable,
  input  logic             periodic,
  input  logic             load_wr,
  input  logic [CNT_W-1:0] load_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] load,
  output logic             fire,
  output logic             done
);

  // A LOAD write restarts the channel, so it suppresses a coincident terminal event.
  assign fire = tick & enable & (count == load) & ~load_wr;
  assign done = fire & ~periodic;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      load  <= '0;
    end else if (load_wr) begin
      load  <= load_data;
      count <= '0;
    end else if (tick && enable) begin
      count <= fire ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_multi_timer.sv
// Wishbone multi-channel timer; prescaler compiled in with WB_MULTI_TIMER_PRESCALE_EN.
import wb_timer_pkg::*;

module wb_multi_timer #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 28,
  parameter logic [29:0] BASE_ADR = 30'h3FFFFFE0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [29:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        RTY_O,
  output logic        interrupt_o
);

`ifdef WB_MULTI_TIMER_PRESCALE_EN
  localparam bit PRESCALE_EN = 1'b1;
`else
  localparam bit PRESCALE_EN = 1'b0;
`endif

  bus_state_e               bus_q, bus_d;
  reg_dec_t                 dec;
  logic                     sel, mapped, take, wr_en;
  logic                     ctrl_wr, status_wr, mask_wr;
  logic [NUM_CH-1:0]        load_wr, w1c;
  logic [NUM_CH-1:0]        en_q, per_q, pend_q, mask_q;
  logic [NUM_CH-1:0]        fire, done;
  logic [CNT_W-1:0]         count_v [NUM_CH];
  logic [CNT_W-1:0]         load_v  [NUM_CH];
  logic [DATA_W-1:0]        rdata;
  logic                     tick;
  logic                     unused_dat;

  assign unused_dat = ^DAT_I;

  assign sel    = CYC_I & STB_I & (ADR_I[29:5] == BASE_ADR[29:5]);
  assign dec    = decode_offset(ADR_I[4:0], NUM_CH, PRESCALE_EN);
  assign mapped = (dec.kind != REG_NONE);

  always_ff @(posedge CLK_I) begin
    if (RST_I) bus_q <= BUS_IDLE;
    else       bus_q <= bus_d;
  end

  // A terminator is always followed by one idle cycle before the next access is taken.
  always_comb begin
    bus_d = BUS_IDLE;
    take  = 1'b0;
    case (bus_q)
      BUS_IDLE: begin
        if (sel) begin
          take  = 1'b1;
          bus_d = mapped ? BUS_ACK : BUS_RTY;
        end
      end
      default: bus_d = BUS_IDLE;
    endcase
  end

  assign ACK_O = (bus_q == BUS_ACK);
  assign RTY_O = (bus_q == BUS_RTY);

  assign wr_en     = take & WE_I & mapped;
  assign ctrl_wr   = wr_en & (dec.kind == REG_CTRL);
  assign status_wr = wr_en & (dec.kind == REG_STATUS);
  assign mask_wr   = wr_en & (dec.kind == REG_MASK);

  always_comb begin
    load_wr = '0;
    w1c     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      load_wr[i] = wr_en && (dec.kind == REG_LOAD) && (dec.ch == 3'(i));
    end
    if (status_wr) w1c = DAT_I[NUM_CH-1:0];
  end

`ifdef WB_MULTI_TIMER_PRESCALE_EN
  logic                  prescale_wr;
  logic [PRESCALE_W-1:0] prescale_q, pdiv_q;

  assign prescale_wr = wr_en & (dec.kind == REG_PRESCALE);
  assign tick        = (pdiv_q == prescale_q);

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      prescale_q <= '0;
      pdiv_q     <= '0;
    end else if (prescale_wr) begin
      prescale_q <= DAT_I[PRESCALE_W-1:0];
      pdiv_q     <= '0;
    end else if (tick) begin
      pdiv_q     <= '0;
    end else begin
      pdiv_q     <= pdiv_q + PRESCALE_W'(1);
    end
  end
`else
  assign tick = 1'b1;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    wb_timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (CLK_I),
      .rst      (RST_I),
      .tick     (tick),
      .enable   (en_q[g]),
      .periodic (per_q[g]),
      .load_wr  (load_wr[g]),
      .load_data(DAT_I[CNT_W-1:0]),
      .count    (count_v[g]),
      .load     (load_v[g]),
      .fire     (fire[g]),
      .done     (done[g])
    );
  end

  // Set beats clear on STATUS, and a CTRL write beats a one-shot self-disable.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      en_q        <= '0;
      per_q       <= '0;
      pend_q      <= '0;
      mask_q      <= '0;
      interrupt_o <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        en_q  <= DAT_I[CTRL_EN_LSB +: NUM_CH];
        per_q <= DAT_I[CTRL_PER_LSB +: NUM_CH];
      end else begin
        en_q  <= en_q & ~done;
      end
      pend_q <= (pend_q & ~w1c) | fire;
      if (mask_wr) mask_q <= DAT_I[NUM_CH-1:0];
      interrupt_o <= |(pend_q & mask_q);
    end
  end

  always_comb begin
    rdata = '0;
    case (dec.kind)
      REG_CTRL: begin
        rdata[CTRL_EN_LSB +: NUM_CH]  = en_q;
        rdata[CTRL_PER_LSB +: NUM_CH] = per_q;
      end
      REG_STATUS: rdata[NUM_CH-1:0] = pend_q;
      REG_MASK:   rdata[NUM_CH-1:0] = mask_q;
`ifdef WB_MULTI_TIMER_PRESCALE_EN
      REG_PRESCALE: rdata[PRESCALE_W-1:0] = prescale_q;
`endif
      REG_LOAD: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (dec.ch == 3'(i)) rdata[CNT_W-1:0] = load_v[i];
        end
      end
      REG_COUNT: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (dec.ch == 3'(i)) rdata[CNT_W-1:0] = count_v[i];
        end
      end
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I)                      DAT_O <= '0;
    else if (take && mapped && !WE_I) DAT_O <= rdata;
  end

endmodule

// File: tb/tb_wb_multi_timer.sv
// Self-checking bench for wb_multi_timer; the prescaler test runs when WB_MULTI_TIMER_PRESCALE_EN is defined.
module tb_wb_multi_timer;

  localparam int unsigned NCH  = 4;
  localparam logic [29:0] BASE = 30'h3FFFFFE0;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [29:0] adr;
  logic [31:0] dat_i, dat_o;
  logic        ack, rty, irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc_cnt  = 0;
  int unsigned last_commit = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt++;

  wb_multi_timer #(
    .NUM_CH  (NCH),
    .CNT_W   (28),
    .BASE_ADR(BASE)
  ) dut (
    .CLK_I      (clk),
    .RST_I      (rst),
    .CYC_I      (cyc),
    .STB_I      (stb),
    .WE_I       (we),
    .ADR_I      (adr),
    .DAT_I      (dat_i),
    .DAT_O      (dat_o),
    .ACK_O      (ack),
    .RTY_O      (rty),
    .interrupt_o(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_until(input int unsigned n);
    while (cyc_cnt < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Bus access: commit edge reported back; at least one idle edge separates accesses.
  task automatic access(input logic w, input logic [4:0] off, input logic [31:0] d,
                        input logic ok, input string tag,
                        output logic [31:0] q, output int unsigned commit);
    wait_until(last_commit + 1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {BASE[29:5], off}; dat_i = d;
    @(posedge clk);
    #1;
    commit = cyc_cnt;
    last_commit = commit;
    check({tag, "_ack"}, {31'b0, ack}, {31'b0, ok});
    check({tag, "_rty"}, {31'b0, rty}, {31'b0, ~ok});
    q = dat_o;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d, output int unsigned commit);
    logic [31:0] q;
    access(1'b1, off, d, 1'b1, "wr", q, commit);
  endtask

  task automatic wr_at(input int unsigned target, input logic [4:0] off, input logic [31:0] d);
    int unsigned c;
    wait_until(target - 1);
    wr(off, d, c);
    check("wr_at_edge", c, target);
  endtask

  task automatic rd(input logic [4:0] off, output logic [31:0] q, output int unsigned commit);
    access(1'b0, off, 32'h0, 1'b1, "rd", q, commit);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] off, input logic [31:0] exp);
    logic [31:0] q;
    int unsigned c;
    rd(off, q, c);
    check(tag, q, exp);
  endtask

  function automatic logic [4:0] load_off(input int unsigned ch);
    return 5'(4 + 2 * ch);
  endfunction

  function automatic logic [4:0] count_off(input int unsigned ch);
    return 5'(5 + 2 * ch);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int unsigned c, e, w, d, r, t;
    int unsigned ld [NCH];
    logic [3:0] per, msk, pend_e;
    logic [31:0] cnt_e [NCH];

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_rty", {31'b0, rty}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    rst = 1'b0;
    last_commit = cyc_cnt;
    rd_chk("rst_ctrl", 5'd0, 32'h0);
    rd_chk("rst_status", 5'd1, 32'h0);
    rd_chk("rst_mask", 5'd2, 32'h0);
    for (int unsigned i = 0; i < NCH; i++) begin
      rd_chk("rst_load", load_off(i), 32'h0);
      rd_chk("rst_count", count_off(i), 32'h0);
    end

    // Periodic channel 0, LOAD=3: terminal event every 4 ticks
    wr(load_off(0), 32'd3, c);
    wr(5'd2, 32'h1, c);
    wr(5'd0, 32'h0101, e);
    wait_until(e + 4);
    check("per_irq_before", {31'b0, irq}, 32'h0);
    wait_until(e + 5);
    check("per_irq_after", {31'b0, irq}, 32'h1);
    for (int k = 0; k < 4; k++) begin
      wait_until(cyc_cnt + $urandom_range(0, 5));
      rd(count_off(0), q, r);
      check("per_count0", q, (r - 1 - e) % 4);
    end
    rd_chk("per_status", 5'd1, 32'h1);

    // W1C coinciding with a terminal event leaves the bit set
    w = e + 4 * ((cyc_cnt + 2 - e) / 4 + 1);
    wr_at(w, 5'd1, 32'h1);
    rd(5'd1, q, r);
    check("w1c_race_status", q, 32'h1);
    wr(5'd0, 32'h0, d);
    wr(5'd1, 32'h1, c);
    check("w1c_irq_hold", {31'b0, irq}, 32'h1);
    wait_until(c + 1);
    check("w1c_irq_fall", {31'b0, irq}, 32'h0);
    rd_chk("w1c_status", 5'd1, 32'h0);

    // One-shot channel 1, LOAD=5
    wr(load_off(1), 32'd5, c);
    wr(5'd0, 32'h0002, e);
    wait_until(e + 12);
    rd_chk("os_status", 5'd1, 32'h2);
    rd_chk("os_ctrl", 5'd0, 32'h0);
    rd_chk("os_count1", count_off(1), 32'h0);
    wait_until(cyc_cnt + 7);
    rd_chk("os_count1_hold", count_off(1), 32'h0);
    check("os_irq_masked", {31'b0, irq}, 32'h0);
    wr(5'd1, 32'h2, c);

    // CTRL write coinciding with a one-shot self-disable wins
    wr(load_off(3), 32'd2, c);
    wr(5'd0, 32'h0008, e);
    wr_at(e + 3, 5'd0, 32'h0008);
    rd_chk("ctrl_wins", 5'd0, 32'h8);
    wait_until(e + 10);
    rd_chk("ctrl_wins_later", 5'd0, 32'h0);
    rd_chk("ctrl_wins_status", 5'd1, 32'h8);
    wr(5'd1, 32'hF, c);

    // LOAD width, read-only COUNT
    wr(load_off(2), 32'hFFFF_FFFF, c);
    rd_chk("load_width", load_off(2), 32'h0FFF_FFFF);
    wr(count_off(2), 32'h55, c);
    rd_chk("count_ro", count_off(2), 32'h0);

    // Unmapped accesses and strobe held high
    rd_chk("mask_pre", 5'd2, 32'h1);
    access(1'b0, 5'd20, 32'h0, 1'b0, "off20", q, c);
    check("off20_dat", q, 32'h1);
    access(1'b1, 5'd31, 32'h1234, 1'b0, "off31", q, c);
`ifndef WB_MULTI_TIMER_PRESCALE_EN
    access(1'b0, 5'd3, 32'h0, 1'b0, "off3", q, c);
    check("off3_dat", q, 32'h1);
`endif
    wait_until(last_commit + 1);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {BASE[29:5], 5'd2};
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check("held_ack", {31'b0, ack}, (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    cyc = 1'b0; stb = 1'b0;
    last_commit = cyc_cnt;

    // Randomized channel runs against arithmetic expectations
    for (int trial = 0; trial < 6; trial++) begin
      wr(5'd1, 32'hF, c);
      per = 4'($urandom_range(0, 15));
      msk = 4'($urandom_range(0, 15));
      for (int unsigned i = 0; i < NCH; i++) begin
        ld[i] = $urandom_range(0, 12);
        wr(load_off(i), ld[i], c);
      end
      wr(5'd2, {28'b0, msk}, c);
      wr(5'd0, {20'b0, per, 4'b0, 4'hF}, e);
      wait_until(e + $urandom_range(3, 40));
      wr(5'd0, 32'h0, d);
      t = d - e;
      pend_e = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        pend_e[i] = (t >= ld[i] + 1);
        if (per[i])       cnt_e[i] = t % (ld[i] + 1);
        else if (pend_e[i]) cnt_e[i] = 0;
        else              cnt_e[i] = t;
      end
      for (int unsigned i = 0; i < NCH; i++) begin
        rd_chk("rnd_count", count_off(i), cnt_e[i]);
        rd_chk("rnd_load", load_off(i), ld[i]);
      end
      rd_chk("rnd_status", 5'd1, {28'b0, pend_e});
      rd_chk("rnd_ctrl", 5'd0, 32'h0);
      check("rnd_irq", {31'b0, irq}, {31'b0, |(pend_e & msk)});
    end
    wr(5'd1, 32'hF, c);

`ifdef WB_MULTI_TIMER_PRESCALE_EN
    begin
      int unsigned p, t1, ev;
      wr(load_off(0), 32'd1, c);
      wr(5'd2, 32'h1, c);
      wr(5'd3, 32'd2, p);
      wr(5'd0, 32'h0101, e);
      t1 = p + 3 * ((e - p) / 3 + 1);
      ev = t1 + 3;
      wait_until(ev);
      check("ps_irq_before", {31'b0, irq}, 32'h0);
      wait_until(ev + 1);
      check("ps_irq_after", {31'b0, irq}, 32'h1);
      rd_chk("ps_prescale", 5'd3, 32'd2);
      rd(count_off(0), q, r);
      check("ps_count0", q, (((r - 1 - p) / 3) - ((e - p) / 3)) % 2);
      wr_at(ev + 7, 5'd1, 32'h1);
      rd(5'd1, q, r);
      check("ps_status_clr", q, (r - 1 >= ev + 12) ? 32'h1 : 32'h0);
      wait_until(ev + 14);
      rd_chk("ps_status_set", 5'd1, 32'h1);
    end
`endif

    // Reset mid-count with an access in flight
    wr(load_off(0), 32'd2, c);
    wr(5'd2, 32'h1, c);
    wr(5'd0, 32'h0101, e);
    wait_until(e + 6);
    @(negedge clk);
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = {BASE[29:5], 5'd2};
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("mid_rst_ack", {31'b0, ack}, 32'h0);
      check("mid_rst_rty", {31'b0, rty}, 32'h0);
      check("mid_rst_irq", {31'b0, irq}, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_ack", {31'b0, ack}, 32'h0);
    last_commit = cyc_cnt;
    rd_chk("post_rst_ctrl", 5'd0, 32'h0);
    rd_chk("post_rst_status", 5'd1, 32'h0);
    rd_chk("post_rst_mask", 5'd2, 32'h0);
`ifdef WB_MULTI_TIMER_PRESCALE_EN
    rd_chk("post_rst_prescale", 5'd3, 32'h0);
`endif
    for (int unsigned i = 0; i < NCH; i++) begin
      rd_chk("post_rst_load", load_off(i), 32'h0);
      rd_chk("post_rst_count", count_off(i), 32'h0);
    end
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_multi_timer.md
WB_MULTI_TIMER -- requirements
Module: wb_multi_timer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of timer channels, legal 1..8.
REQ-002 SHALL have parameter CNT_W, default 28, counter/load width, legal 8..32.
REQ-003 SHALL have parameter BASE_ADR, default 30'h3FFFFFE0, word address of register window; bits [4:0] ignored.
REQ-004 SHALL have port CLK_I input 1 system clock; one clock, all state on rising edge.
REQ-005 SHALL have port RST_I input 1 reset; synchronous, active-high.
REQ-006 SHALL have ports CYC_I, STB_I, WE_I, each input 1, Wishbone cycle, strobe and write enable.
REQ-007 SHALL have port ADR_I input 30 word address.
REQ-008 SHALL have port DAT_I input 32 write data.
REQ-009 SHALL have port DAT_O output 32 registered read data.
REQ-010 SHALL have ports ACK_O, RTY_O, each output 1, registered access terminators.
REQ-011 SHALL have port interrupt_o output 1 registered OR of enabled pending channels.

Function
REQ-012 SHALL select the window when CYC_I&STB_I and ADR_I[29:5]==BASE_ADR[29:5]; offset = ADR_I[4:0].
REQ-013 SHALL register map: 0 CTRL (bits[7:0] enable per channel, bits[15:8] periodic mode), 1 STATUS (pending, write-1-to-clear), 2 MASK, 3 PRESCALE, 4+2*ch LOAD[ch], 5+2*ch COUNT[ch] (read-only); unused bits read 0.
REQ-014 SHALL terminate a selected access one cycle after strobe: ACK_O for mapped offsets, RTY_O for unmapped offsets or ch>=NUM_CH; exactly one terminator per access.
REQ-015 SHALL deassert ACK_O/RTY_O for one cycle after each termination, so a held strobe gives one termination per two cycles.
REQ-016 SHALL apply writes in the ACK cycle; SHALL ignore writes to COUNT and to unmapped offsets.
REQ-017 SHALL advance an enabled channel counter by 1 per tick (tick = every cycle, or per REQ-027); disabled channels hold.
REQ-018 SHALL, when an enabled channel's COUNT equals LOAD on a tick, set its pending bit; periodic mode: COUNT<=0 and stay enabled; one-shot: COUNT<=0 and clear its CTRL enable bit.
REQ-019 SHALL clear COUNT to 0 on any LOAD write for that channel; LOAD==0 gives a terminal event every tick.
REQ-020 SHALL, when set and W1C of the same pending bit occur in one cycle, leave the bit set.
REQ-021 SHALL, when a CTRL write and a one-shot self-disable coincide, apply the CTRL write.
REQ-022 SHALL drive interrupt_o = |(STATUS & MASK) registered, one cycle after the pending bit changes.
REQ-023 SHALL wrap counter arithmetic modulo 2^CNT_W; LOAD/COUNT zero-extended to 32 on read.

Reset
REQ-024 SHALL clear CTRL, STATUS, MASK, all COUNT, all LOAD, PRESCALE, DAT_O, ACK_O, RTY_O, interrupt_o while RST_I is high.
REQ-025 SHALL abandon any in-flight access on reset; no termination issued for it.

Configuration
REQ-026 SHALL compile prescaler support only when WB_MULTI_TIMER_PRESCALE_EN is defined.
REQ-027 SHALL, with the macro, use a 16-bit PRESCALE register and free-running divider producing one tick every PRESCALE+1 cycles, divider restarting on PRESCALE write.
REQ-028 SHALL, without the macro, tick every cycle; offset 3 unmapped (RTY_O).

Structure
REQ-029 SHALL place register offsets, CTRL field positions and the 32-bit data width in shared package wb_timer_pkg.
REQ-030 SHALL implement one channel (counter, terminal compare, mode) as sub-module wb_timer_channel, instantiated NUM_CH times.

Verification
REQ-031 SHALL test: LOAD0=3, CTRL=0x0101, MASK=1 -> STATUS bit0 set every 4 cycles, interrupt_o high 1 cycle after first set.
REQ-032 SHALL test: one-shot LOAD1=5, CTRL=0x0002 -> single pending bit1, CTRL bit1 reads 0, COUNT1 stays 0.
REQ-033 SHALL test: W1C STATUS=0x1 in the cycle channel 0 terminates -> bit0 remains 1; next W1C clears, interrupt_o falls 1 cycle later.
REQ-034 SHALL test: read offset 20 with NUM_CH=4 -> RTY_O pulse, ACK_O low, DAT_O unchanged.
REQ-035 SHALL test: RST_I asserted mid-count, then released -> all registers read 0, interrupt_o 0, no stray ACK_O.
REQ-036 SHALL test with macro: PRESCALE=2, LOAD0=1 -> pending every 6 cycles; without macro offset 3 -> RTY_O.
